// File: rtl/xnor_compare_arbiter_if.sv
// Request/response bundle for xnor_compare_arbiter.
//   master : operand producer side; drives req*_valid/a/b and observes
//            req*_ready and the rsp_* result pulse.
//   slave  : the compare block; observes requests and drives ready/response.
// WIDTH must match the WIDTH of the attached xnor_compare_arbiter.
interface xnor_compare_arbiter_if #(
  parameter int unsigned WIDTH = 8
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_match;
  logic             rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_match, rsp_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_match, rsp_id
  );

endinterface

// File: rtl/xnor_compare_arbiter.sv
// Two-port round-robin front end sharing one bit-serial XNOR equality stage.
// Each accepted operand pair is shifted LSB-first through a 1-bit XNOR and
// AND-accumulated; the result leaves as a one-cycle pulse tagged with the
// owning requester's ID.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous, active-high reset
//   bus   - xnor_compare_arbiter_if.slave: req0/req1 valid/ready/a/b,
//           rsp_valid/rsp_match/rsp_id
//   busy  - high whenever the FSM is not in IDLE
//
// Build option:
//   XNOR_CMP_EARLY_EXIT_EN - when defined, the first mismatching bit ends the
//   shift phase immediately (response with rsp_match=0). Interface unchanged.
module xnor_compare_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  xnor_compare_arbiter_if.slave bus,
  output logic                  busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CNT_W-1:0] bit_cnt;
  logic             acc;
  logic             id;
  logic             last_grant;

  logic             grant0_c;
  logic             grant1_c;
  logic             bit_eq_c;
  logic             last_bit_c;

  // Round-robin grant; only offered in IDLE and never while reset is held.
  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state == IDLE && !rst) begin
      if (bus.req0_valid && (!bus.req1_valid || last_grant)) begin
        grant0_c = 1'b1;
      end else if (bus.req1_valid) begin
        grant1_c = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant0_c;
  assign bus.req1_ready = grant1_c;

  // Current bit comparison and end-of-shift decision.
  assign bit_eq_c = ~(sa[0] ^ sb[0]);

`ifdef XNOR_CMP_EARLY_EXIT_EN
  assign last_bit_c = (bit_cnt == LAST_BIT) || !bit_eq_c;
`else
  assign last_bit_c = (bit_cnt == LAST_BIT);
`endif

  // Control FSM with datapath and registered response/busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sa            <= '0;
      sb            <= '0;
      bit_cnt       <= '0;
      acc           <= 1'b0;
      id            <= 1'b0;
      last_grant    <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_match <= 1'b0;
      bus.rsp_id    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.rsp_valid <= 1'b0;
          if (grant0_c || grant1_c) begin
            sa         <= grant1_c ? bus.req1_a : bus.req0_a;
            sb         <= grant1_c ? bus.req1_b : bus.req0_b;
            id         <= grant1_c;
            last_grant <= grant1_c;
            acc        <= 1'b1;
            bit_cnt    <= '0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          acc     <= acc & bit_eq_c;
          sa      <= sa >> 1;
          sb      <= sb >> 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (last_bit_c) begin
            // Response registers load on the way into DONE so they are
            // valid for exactly the DONE cycle.
            bus.rsp_valid <= 1'b1;
            bus.rsp_match <= acc & bit_eq_c;
            bus.rsp_id    <= id;
            state         <= DONE;
          end
        end

        DONE: begin
          bus.rsp_valid <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end

        default: begin
          bus.rsp_valid <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
